// File: rtl/srio_tx_sched.sv
// srio_tx_sched: two-requester round-robin scheduler driving the SRIO user configuration port.
// Define SRIO_SCHED_DB_EN to build the doorbell phase (DB/WDB) after each successful transfer.
`timescale 1ns/1ps
module srio_tx_sched #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned MAX_BYTES   = 256
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  dest_id0,
    input  logic [7:0]  dest_id1,
    input  logic [31:0] src_addr0,
    input  logic [31:0] src_addr1,
    input  logic [33:0] dest_addr0,
    input  logic [33:0] dest_addr1,
    input  logic [8:0]  byte_cnt0,
    input  logic [8:0]  byte_cnt1,
    input  logic [15:0] db_info0,
    input  logic [15:0] db_info1,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [7:0]  ucfg_dest_id,
    output logic [31:0] ucfg_src_start_addr,
    output logic [33:0] ucfg_dest_start_addr,
    output logic [8:0]  ucfg_byte_count,
    output logic [15:0] ucfg_db_info,
    output logic        ucfg_wr_n,
    output logic        ucfg_normal_trigger,
    output logic        ucfg_db_trigger,
    input  logic        srio_initial_busy,
    input  logic        srio_db_resp,
    output logic        sched_idle
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_TRIG    = 3'd2;
    localparam logic [2:0] S_WBUSY_H = 3'd3;
    localparam logic [2:0] S_WBUSY_L = 3'd4;
`ifdef SRIO_SCHED_DB_EN
    localparam logic [2:0] S_DB      = 3'd5;
    localparam logic [2:0] S_WDB     = 3'd6;
`endif
    localparam logic [2:0] S_FIN     = 3'd7;

    localparam int unsigned    CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]  TO_SAT  = CW'(TIMEOUT_CYC);

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_ptr;
    logic          r_owner;
    logic          r_bad;
    logic          r_ack0, r_ack1;
    logic          r_done0, r_done1;
    logic          r_err0, r_err1;
    logic          r_ntrig;
    logic [7:0]    r_ucfg_dest_id;
    logic [31:0]   r_ucfg_src;
    logic [33:0]   r_ucfg_dst;
    logic [8:0]    r_ucfg_cnt;

    logic [2:0]    w_state_nxt;
    logic          w_sel;
    logic          w_grant;
    logic          w_cnt_bad;
    logic [8:0]    w_cnt_sel;
    logic          w_tmo;
    logic          w_err;
    logic          w_done;
    logic          w_ntrig;

`ifdef SRIO_SCHED_DB_EN
    logic          r_dbtrig;
    logic [15:0]   r_ucfg_db;
    logic          w_dbtrig;
`else
    logic          w_unused_db;
    assign w_unused_db = ^{srio_db_resp, db_info0, db_info1};
`endif

    // The descriptor is validated and loaded into ucfg_* at grant time, so the fields are
    // already stable during LOAD, one cycle ahead of the trigger pulse in TRIG.
    always_comb begin
        w_sel       = (req0 & req1) ? r_ptr : req1;
        w_cnt_sel   = w_sel ? byte_cnt1 : byte_cnt0;
        w_cnt_bad   = (w_cnt_sel == '0) || (32'(w_cnt_sel) > MAX_BYTES);
        w_tmo       = (r_cnt == TO_LAST);
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_err       = 1'b0;
        w_done      = 1'b0;
        w_ntrig     = 1'b0;
`ifdef SRIO_SCHED_DB_EN
        w_dbtrig    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if ((req0 | req1) && !srio_initial_busy) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_bad) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ntrig     = 1'b1;
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: w_state_nxt = S_WBUSY_H;
            S_WBUSY_H: begin
                if (srio_initial_busy) begin
                    w_state_nxt = S_WBUSY_L;
                end else if (w_tmo) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WBUSY_L: begin
                if (!srio_initial_busy) begin
`ifdef SRIO_SCHED_DB_EN
                    w_dbtrig    = 1'b1;
                    w_state_nxt = S_DB;
`else
                    w_done      = 1'b1;
                    w_state_nxt = S_FIN;
`endif
                end else if (w_tmo) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`ifdef SRIO_SCHED_DB_EN
            S_DB: w_state_nxt = S_WDB;
            S_WDB: begin
                if (srio_db_resp) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_FIN;
                end else if (w_tmo) begin
                    w_err       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_ptr          <= 1'b0;
            r_owner        <= 1'b0;
            r_bad          <= 1'b0;
            r_ack0         <= 1'b0;
            r_ack1         <= 1'b0;
            r_done0        <= 1'b0;
            r_done1        <= 1'b0;
            r_err0         <= 1'b0;
            r_err1         <= 1'b0;
            r_ntrig        <= 1'b0;
            r_ucfg_dest_id <= '0;
            r_ucfg_src     <= '0;
            r_ucfg_dst     <= '0;
            r_ucfg_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_cnt != TO_SAT) begin
                r_cnt <= r_cnt + CW'(1);
            end
            r_ack0  <= w_grant & ~w_sel;
            r_ack1  <= w_grant & w_sel;
            r_err0  <= w_err & ~r_owner;
            r_err1  <= w_err & r_owner;
            r_done0 <= w_done & ~r_owner;
            r_done1 <= w_done & r_owner;
            r_ntrig <= w_ntrig;
            if (w_grant) begin
                r_owner <= w_sel;
                r_ptr   <= ~w_sel;
                r_bad   <= w_cnt_bad;
                if (!w_cnt_bad) begin
                    r_ucfg_dest_id <= w_sel ? dest_id1   : dest_id0;
                    r_ucfg_src     <= w_sel ? src_addr1  : src_addr0;
                    r_ucfg_dst     <= w_sel ? dest_addr1 : dest_addr0;
                    r_ucfg_cnt     <= w_cnt_sel;
                end
            end
        end
    end

`ifdef SRIO_SCHED_DB_EN
    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            r_dbtrig  <= 1'b0;
            r_ucfg_db <= '0;
        end else begin
            r_dbtrig <= w_dbtrig;
            if (w_grant && !w_cnt_bad) begin
                r_ucfg_db <= w_sel ? db_info1 : db_info0;
            end
        end
    end

    assign ucfg_db_trigger = r_dbtrig;
    assign ucfg_db_info    = r_ucfg_db;
`else
    assign ucfg_db_trigger = 1'b0;
    assign ucfg_db_info    = '0;
`endif

    assign ack0                 = r_ack0;
    assign ack1                 = r_ack1;
    assign done0                = r_done0;
    assign done1                = r_done1;
    assign err0                 = r_err0;
    assign err1                 = r_err1;
    assign ucfg_dest_id         = r_ucfg_dest_id;
    assign ucfg_src_start_addr  = r_ucfg_src;
    assign ucfg_dest_start_addr = r_ucfg_dst;
    assign ucfg_byte_count      = r_ucfg_cnt;
    assign ucfg_wr_n            = 1'b0;
    assign ucfg_normal_trigger  = r_ntrig;
    assign sched_idle           = (r_state == S_IDLE);

endmodule

// File: tb/tb_srio_tx_sched.sv
// Directed bench for srio_tx_sched with a small SRIO core responder; TIMEOUT_CYC is set to 64.
`timescale 1ns/1ps
module tb_srio_tx_sched;

    localparam int W_ACK   = 0;
    localparam int W_END   = 1;
    localparam int W_BUSY1 = 2;
    localparam int W_BUSY0 = 3;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        req0, req1;
    logic [7:0]  dest_id0, dest_id1;
    logic [31:0] src_addr0, src_addr1;
    logic [33:0] dest_addr0, dest_addr1;
    logic [8:0]  byte_cnt0, byte_cnt1;
    logic [15:0] db_info0, db_info1;
    logic        ack0, ack1, done0, done1, err0, err1;
    logic [7:0]  ucfg_dest_id;
    logic [31:0] ucfg_src_start_addr;
    logic [33:0] ucfg_dest_start_addr;
    logic [8:0]  ucfg_byte_count;
    logic [15:0] ucfg_db_info;
    logic        ucfg_wr_n, ucfg_normal_trigger, ucfg_db_trigger;
    logic        srio_initial_busy, srio_db_resp;
    logic        sched_idle;

    int  n_checks = 0;
    int  n_fail   = 0;

    int  n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;
    int  n_ntrig = 0, n_dbtrig = 0, n_excl = 0;
    int  grant_q[$];
    time ntrig_t = 0, done_t = 0, err_t = 0, fall_t = 0, dbresp_t = 0;
    logic [8:0] last_bc = '0;
    logic [7:0] last_dest = '0;

    int  core_en = 0, busy_dly = 1, busy_len = 2, db_dly = 2;

`ifdef SRIO_SCHED_DB_EN
    localparam int EXP_DB = 1;
`else
    localparam int EXP_DB = 0;
`endif

    srio_tx_sched #(.TIMEOUT_CYC(64), .MAX_BYTES(256)) dut (
        .user_clk             (user_clk),
        .user_rst             (user_rst),
        .req0                 (req0),
        .req1                 (req1),
        .dest_id0             (dest_id0),
        .dest_id1             (dest_id1),
        .src_addr0            (src_addr0),
        .src_addr1            (src_addr1),
        .dest_addr0           (dest_addr0),
        .dest_addr1           (dest_addr1),
        .byte_cnt0            (byte_cnt0),
        .byte_cnt1            (byte_cnt1),
        .db_info0             (db_info0),
        .db_info1             (db_info1),
        .ack0                 (ack0),
        .ack1                 (ack1),
        .done0                (done0),
        .done1                (done1),
        .err0                 (err0),
        .err1                 (err1),
        .ucfg_dest_id         (ucfg_dest_id),
        .ucfg_src_start_addr  (ucfg_src_start_addr),
        .ucfg_dest_start_addr (ucfg_dest_start_addr),
        .ucfg_byte_count      (ucfg_byte_count),
        .ucfg_db_info         (ucfg_db_info),
        .ucfg_wr_n            (ucfg_wr_n),
        .ucfg_normal_trigger  (ucfg_normal_trigger),
        .ucfg_db_trigger      (ucfg_db_trigger),
        .srio_initial_busy    (srio_initial_busy),
        .srio_db_resp         (srio_db_resp),
        .sched_idle           (sched_idle)
    );

    always #5 user_clk = ~user_clk;

    // SRIO core responder: busy pulse after each normal trigger, doorbell response after db trigger.
    initial begin
        srio_initial_busy = 1'b0;
        srio_db_resp      = 1'b0;
        forever begin
            @(negedge user_clk);
            if (core_en != 0 && ucfg_normal_trigger) begin
                repeat (busy_dly) @(negedge user_clk);
                srio_initial_busy = 1'b1;
                repeat (busy_len) @(negedge user_clk);
                srio_initial_busy = 1'b0;
                fall_t = $time;
            end else if (core_en != 0 && ucfg_db_trigger) begin
                repeat (db_dly) @(negedge user_clk);
                srio_db_resp = 1'b1;
                dbresp_t = $time;
                @(negedge user_clk);
                srio_db_resp = 1'b0;
            end
        end
    end

    always @(negedge user_clk) begin
        if (ack0) begin n_ack0++; grant_q.push_back(0); end
        if (ack1) begin n_ack1++; grant_q.push_back(1); end
        if (done0) n_done0++;
        if (done1) n_done1++;
        if (err0) n_err0++;
        if (err1) n_err1++;
        if (done0 | done1) done_t = $time;
        if (err0 | err1) err_t = $time;
        if (ucfg_normal_trigger) begin
            n_ntrig++;
            ntrig_t   = $time;
            last_bc   = ucfg_byte_count;
            last_dest = ucfg_dest_id;
        end
        if (ucfg_db_trigger) n_dbtrig++;
        if (int'(ack0) + int'(ack1) + int'(done0) + int'(done1) + int'(err0) + int'(err1) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge user_clk);
        #1;
    endtask

    task automatic wait_for(input string tag, input int sel, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            case (sel)
                W_ACK:   hit = ack0 | ack1;
                W_END:   hit = done0 | done1 | err0 | err1;
                W_BUSY1: hit = srio_initial_busy;
                default: hit = !srio_initial_busy;
            endcase
        end
        check(tag, 64'(hit), 64'd1);
    endtask

    initial begin
        int acks;
        int base_a, base_b, base_c;
        int bad_cnt [2] = '{0, 300};

        user_rst   = 1'b1;
        req0       = 1'b0;
        req1       = 1'b0;
        dest_id0   = 8'd20;           dest_id1   = 8'd33;
        src_addr0  = 32'h0000_1000;   src_addr1  = 32'h0000_5000;
        dest_addr0 = 34'h2_0000_2000; dest_addr1 = 34'h1_0000_6000;
        byte_cnt0  = 9'd16;           byte_cnt1  = 9'd20;
        db_info0   = 16'hBEEF;        db_info1   = 16'h1234;

        repeat (3) step();
        check("rst_idle",     64'(sched_idle), 64'd1);
        check("rst_ack0",     64'(ack0), 64'd0);
        check("rst_trig",     64'(ucfg_normal_trigger), 64'd0);
        check("rst_bcnt",     64'(ucfg_byte_count), 64'd0);
        check("rst_dest",     64'(ucfg_dest_id), 64'd0);
        check("rst_wr_n",     64'(ucfg_wr_n), 64'd0);
        user_rst = 1'b0;
        step();
        check("rel_no_trig",  64'(ucfg_normal_trigger), 64'd0);

        // Round robin with both requesters held from the same cycle.
        core_en = 1; busy_dly = 1; busy_len = 2; db_dly = 2;
        req0 = 1'b1; req1 = 1'b1; acks = 0;
        for (int i = 0; i < 400 && acks < 4; i++) begin
            step();
            if (ack0 | ack1) acks++;
        end
        req0 = 1'b0; req1 = 1'b0;
        check("rr_acks", 64'(acks), 64'd4);
        wait_for("rr_end_wait", W_END, 200);
        step();
        check("rr_count", 64'(grant_q.size()), 64'd4);
        if (grant_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) check("rr_order", 64'(grant_q[k]), 64'(k % 2));
        end
        check("rr_done0", 64'(n_done0), 64'd2);
        check("rr_done1", 64'(n_done1), 64'd2);

        // Illegal byte counts on requester 1: ack then err, never a trigger.
        base_a = n_ntrig;
        base_b = n_done1;
        for (int j = 0; j < 2; j++) begin
            byte_cnt1 = 9'(bad_cnt[j]);
            req1 = 1'b1;
            wait_for("bad_ack_wait", W_ACK, 20);
            check("bad_ack1", 64'(ack1), 64'd1);
            req1 = 1'b0;
            wait_for("bad_end_wait", W_END, 20);
            check("bad_err1", 64'(err1), 64'd1);
            step();
        end
        check("bad_no_trig", 64'(n_ntrig - base_a), 64'd0);
        check("bad_no_done", 64'(n_done1 - base_b), 64'd0);

        // Normal transfer on requester 0.
        byte_cnt0 = 9'd10; dest_id0 = 8'd20;
        busy_dly = 5; busy_len = 4; db_dly = 3;
        base_a = n_ntrig; base_b = n_dbtrig; base_c = n_err0;
        req0 = 1'b1;
        wait_for("a_ack_wait", W_ACK, 20);
        check("a_ack0", 64'(ack0), 64'd1);
        req0 = 1'b0;
        check("a_busy_sched", 64'(sched_idle), 64'd0);
        wait_for("a_end_wait", W_END, 200);
        check("a_done0", 64'(done0), 64'd1);
`ifdef SRIO_SCHED_DB_EN
        check("a_done_lat", 64'(done_t - dbresp_t), 64'd10);
`else
        check("a_done_lat", 64'(done_t - fall_t), 64'd10);
`endif
        check("a_bcnt",    64'(ucfg_byte_count), 64'd10);
        check("a_dest",    64'(ucfg_dest_id), 64'd20);
        check("a_src",     64'(ucfg_src_start_addr), 64'h0000_1000);
        check("a_daddr",   64'(ucfg_dest_start_addr), 64'h2_0000_2000);
        check("a_dbinfo",  64'(ucfg_db_info), EXP_DB != 0 ? 64'hBEEF : 64'h0);
        step();
        check("a_ntrig",   64'(n_ntrig - base_a), 64'd1);
        check("a_trig_bc", 64'(last_bc), 64'd10);
        check("a_dbtrig",  64'(n_dbtrig - base_b), 64'(EXP_DB));
        check("a_no_err",  64'(n_err0 - base_c), 64'd0);

        // Timeout: the core never raises busy.
        core_en = 0;
        base_a = n_done0;
        req0 = 1'b1;
        wait_for("to_ack_wait", W_ACK, 20);
        req0 = 1'b0;
        wait_for("to_end_wait", W_END, 200);
        check("to_err0",  64'(err0), 64'd1);
        check("to_lat",   64'(err_t - ntrig_t), 64'd650);
        check("to_idle",  64'(sched_idle), 64'd1);
        step();
        check("to_idle2", 64'(sched_idle), 64'd1);
        check("to_no_done", 64'(n_done0 - base_a), 64'd0);

        // Reset while waiting for busy to fall, then a normal transfer.
        core_en = 1; busy_dly = 2; busy_len = 20;
        byte_cnt0 = 9'd40;
        req0 = 1'b1;
        wait_for("rs_ack_wait", W_ACK, 20);
        req0 = 1'b0;
        wait_for("rs_busy_wait", W_BUSY1, 50);
        repeat (3) step();
        check("rs_in_xfer", 64'(sched_idle), 64'd0);
        user_rst = 1'b1;
        #2;
        check("rs_idle",  64'(sched_idle), 64'd1);
        check("rs_bcnt",  64'(ucfg_byte_count), 64'd0);
        check("rs_dest",  64'(ucfg_dest_id), 64'd0);
        check("rs_src",   64'(ucfg_src_start_addr), 64'd0);
        check("rs_pulse", 64'({ack0, ack1, done0, done1, err0, err1, ucfg_normal_trigger, ucfg_db_trigger}), 64'd0);
        step();
        user_rst = 1'b0;
        wait_for("rs_busy0_wait", W_BUSY0, 40);
        step();
        check("rs_idle_rel", 64'(sched_idle), 64'd1);
        byte_cnt0 = 9'd33;
        busy_len = 3;
        base_a = n_ntrig;
        req0 = 1'b1;
        wait_for("rs2_ack_wait", W_ACK, 20);
        check("rs2_ack0", 64'(ack0), 64'd1);
        req0 = 1'b0;
        wait_for("rs2_end_wait", W_END, 200);
        check("rs2_done0", 64'(done0), 64'd1);
        step();
        check("rs2_ntrig", 64'(n_ntrig - base_a), 64'd1);
        check("rs2_bc",    64'(last_bc), 64'd33);
        check("rs2_destid", 64'(last_dest), 64'd20);

        check("excl_pulses", 64'(n_excl), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
